// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS-style sequencer: state encoding, opcodes,
// datapath select encodings and the Moore output decode.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_START     = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXEC      = 4'd7,
        ST_R_WB      = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_TRAP      = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEN   = 6'h14;
    localparam logic [5:0] OP_BVF   = 6'h15;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       trap;
    } ctrl_t;

    // State-only part of the outputs; ready- and flag-qualified strobes are added in the top.
    function automatic ctrl_t moore_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_req   = 1'b1;
                c.pc_src    = PCSRC_ALU;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
            end
            ST_DECODE: begin
                c.alu_src_b = SRCB_IMM_SL2;
                c.alu_op    = ALU_ADD;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            ST_MEM_READ: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
            end
            ST_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALU_SUB;
                c.pc_src    = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                c.pc_src   = PCSRC_JUMP;
                c.pc_write = 1'b1;
            end
            ST_TRAP:  c.trap = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_mem_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait counter: clears on start, counts cycles without ready, flags expiry
// when the count sits at TIMEOUT and ready is still low. TIMEOUT=0 never expires.
module multicycle_ctrl_mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic ready_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: combinational next-state gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = '0;
        end else if (!ready_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && !ready_i && (count_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multi-cycle MIPS-style datapath with memory handshake,
// timeout trap and retire counter. STATUS_BRANCH_EN adds ben/bvf via a latched cpsr.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned RET_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zout,
    input  logic             sout,
    input  logic             oout,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             trap,
    output logic [RET_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q;
    logic [RET_W-1:0] retired_q;
    logic             timer_start, timer_expired;
    logic             retire, fetch_done, br_take;

    multicycle_ctrl_mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (timer_start),
        .ready_i   (mem_ready),
        .expired_o (timer_expired)
    );

    assign timer_start = is_mem_state(state_d) && (state_d != state_q);
    assign fetch_done  = (state_q == ST_FETCH) && mem_ready;
    assign retire      = (state_q == ST_MEM_WB) || (state_q == ST_R_WB) ||
                         (state_q == ST_BRANCH) || (state_q == ST_JUMP) ||
                         ((state_q == ST_MEM_WRITE) && mem_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)          state_d = ST_DECODE;
                else if (timer_expired) state_d = ST_TRAP;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
`ifdef STATUS_BRANCH_EN
                    OP_BEN, OP_BVF: state_d = ST_BRANCH;
`endif
                    default:      state_d = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ: begin
                if (mem_ready)          state_d = ST_MEM_WB;
                else if (timer_expired) state_d = ST_TRAP;
            end
            ST_MEM_WRITE: begin
                if (mem_ready)          state_d = ST_FETCH;
                else if (timer_expired) state_d = ST_TRAP;
            end
            ST_EXEC:                       state_d = ST_R_WB;
            ST_MEM_WB, ST_R_WB,
            ST_BRANCH, ST_JUMP:            state_d = ST_FETCH;
            ST_TRAP:                       state_d = ST_TRAP;
            default:                       state_d = ST_TRAP;
        endcase
    end

    // NOTE: outputs are registered from state_d so they always match state_q with no decode after the flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_START;
            ctrl_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= moore_ctrl(state_d);
            if (retire) retired_q <= retired_q + RET_W'(1);
        end
    end

`ifdef STATUS_BRANCH_EN
    logic [2:0] cpsr_q;  // {s, o, z}
    logic       unused_cpsr_z;

    assign unused_cpsr_z = cpsr_q[0];

    always_comb begin
        case (opcode)
            OP_BEN:  br_take = cpsr_q[2];
            OP_BVF:  br_take = cpsr_q[1];
            default: br_take = zout;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpsr_q <= '0;
        end else if (state_q == ST_EXEC) begin
            cpsr_q <= {sout, oout, zout};
        end else if ((state_q == ST_BRANCH) && br_take &&
                     ((opcode == OP_BEN) || (opcode == OP_BVF))) begin
            cpsr_q <= '0;
        end
    end
`else
    logic unused_flags;

    assign unused_flags = ^{sout, oout};
    assign br_take      = zout;
`endif

    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign iord       = ctrl_q.iord;
    assign ir_write   = fetch_done;
    assign pc_write   = ctrl_q.pc_write | fetch_done | ((state_q == ST_BRANCH) && br_take);
    assign pc_src     = ctrl_q.pc_src;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign reg_write  = ctrl_q.reg_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign trap       = ctrl_q.trap;
    assign retired    = retired_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the 32-bit MIPS-style datapath: one shared ALU and one byte-addressed unified memory, with instructions taking 3–5 states.
- Moore FSM drives all mux selects, write enables and the 2-bit ALU op consumed by the existing ALU-control decoder (aluop1/aluop0).
- Adds a memory ready/req handshake with timeout, and a retired-instruction counter.

Parameters:
- TIMEOUT, 16, max cycles waiting for mem_ready in a memory state; 0 disables the timeout.
- RET_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction bits [31:26] from the instruction register.
- zout  in  1  ALU zero flag.
- sout  in  1  ALU sign flag.
- oout  in  1  ALU overflow flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, valid with mem_req.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load instruction register.
- pc_write  out  1  load PC.
- pc_src  out  2  PC source: 0=ALU result, 1=ALUOut (branch target), 2=jump target {pc[31:28],instr[25:0],2'b00}.
- alu_src_a  out  1  ALU A input: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B input: 0=rt, 1=const 4, 2=sext imm, 3=sext imm<<2.
- alu_op  out  2  ALU op: 00=add, 01=sub, 10=funct-decoded.
- reg_write  out  1  register file write.
- reg_dst  out  1  destination register: 0=rt, 1=rd.
- mem_to_reg  out  1  write-back source: 0=ALUOut, 1=MDR.
- trap  out  1  sticky fault flag.
- retired  out  RET_W  count of completed instructions.
- state_dbg  out  4  current state encoding.

Behaviour:
- State encoding: START=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC=7, R_WB=8, BRANCH=9, JUMP=10, TRAP=11.
- Reset (async, rst_n low): state=START, retired=0, cpsr=0, timeout counter=0. All outputs 0 in START. START→FETCH unconditionally.
- Outputs are a pure function of state. The only exceptions are pc_write in BRANCH and the ready-qualified strobes listed below.
- FETCH:
  - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=00.
  - Holds while mem_ready=0.
  - On mem_ready=1, in the same cycle: ir_write=1, pc_write=1, pc_src=0; next state DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=3, alu_op=00 (branch target latched into ALUOut).
  - Dispatch on opcode: 0x00→EXEC; 0x23 (lw) or 0x2B (sw)→MEM_ADDR; 0x04 (beq)→BRANCH; 0x02 (j)→JUMP; anything else→TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=00. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_req=1, iord=1; waits on mem_ready, then →MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; retire; →FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, iord=1; waits on mem_ready, then retire; →FETCH.
- EXEC:
  - Drives alu_src_a=1, alu_src_b=0, alu_op=10.
  - Latches cpsr={sout,oout,zout} at the clock edge; →R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; retire; →FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=0, alu_op=01, pc_src=1, pc_write=zout.
  - Retire; →FETCH. Branch not taken leaves PC unchanged (already PC+4).
- JUMP: pc_src=2, pc_write=1; retire; →FETCH.
- TRAP: all outputs 0, trap=1. Absorbing state; only reset exits.
- Retire means retired increments by 1 on leaving the state. It wraps from 2^RET_W−1 to 0 with no flag.
- Memory wait:
  - The counter clears on entry to any memory state and increments each cycle mem_ready=0.
  - If TIMEOUT≠0 and the count reaches TIMEOUT with mem_ready still 0, next state is TRAP.
  - If mem_ready rises in the cycle the count reaches TIMEOUT, mem_ready wins.
- mem_ready outside a memory state is ignored.
- Reset mid-access: mem_req drops asynchronously. No partial write is reported and retired is not incremented.

Optional Feature:
- Macro STATUS_BRANCH_EN.
- Defined: DECODE also dispatches opcode 0x14 (ben) and 0x15 (bvf) to BRANCH. In BRANCH, pc_write = cpsr.s for ben, cpsr.o for bvf, zout for beq. cpsr is cleared to 0 after any taken ben/bvf.
- Undefined: 0x14 and 0x15 go to TRAP; cpsr logic is not synthesised.

Decomposition:
- Shared package: state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_BEN, OP_BVF), ALU op codes, alu_src_b and pc_src encodings.
- One sub-module, mem_wait_timer: counter plus timeout compare, with inputs start/ready and output expired.

Test Plan:
- Reset release, mem_ready tied 1, R-type add (opcode 0x00) → states 0,1,2,7,8,1. reg_write=1 with reg_dst=1 in R_WB; retired=1.
- lw with mem_ready low for 3 cycles in MEM_READ → MEM_READ held exactly 4 cycles. MEM_WB asserts mem_to_reg=1; total 5 states plus the 3 wait cycles.
- beq with zout=1 → pc_write=1, pc_src=1 in BRANCH. Repeat with zout=0 → pc_write=0; both cases retire.
- Opcode 0x3F → TRAP after DECODE, trap=1 stays set for 10 cycles. rst_n pulse → START then FETCH, trap=0, retired=0.
- TIMEOUT=16, mem_ready held 0 in FETCH → TRAP on cycle 17. mem_ready=1 at count 16 → DECODE instead.
- STATUS_BRANCH_EN: R-type leaving sout=1, then ben → pc_write=1 and cpsr cleared. bvf with oout=0 → pc_write=0.
